// File: rtl/mapper_mmc1_gen.sv
// mapper_mmc1_gen: MMC1-family (SxROM) mapper with write filter, outer-bank reuse of CHR regs and size masks
module mapper_mmc1_gen #(
  parameter int PRG_ROM_AW = 19,
  parameter int PRG_RAM_AW = 15,
  parameter int CHR_AW     = 17,
  parameter int WR_FILTER  = 1,
  parameter int MMC1B      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_cycle_i,
  input  logic                  mapper_wr_i,
  input  logic [14:0]           mapper_addr_i,
  input  logic [7:0]            mapper_wr_data_i,
  input  logic [14:0]           prg_rom_addr_i,
  input  logic [12:0]           prg_ram_addr_i,
  input  logic [12:0]           chr_mem_addr_i,
  input  logic [PRG_ROM_AW-1:0] prg_rom_mask_i,
  input  logic [CHR_AW-1:0]     chr_mem_mask_i,
  input  logic                  chr_mem_is_ram_i,
  input  logic                  prg_rom_is_512k_i,
  output logic [PRG_ROM_AW-1:0] prg_rom_addr_o,
  output logic [PRG_RAM_AW-1:0] prg_ram_addr_o,
  output logic [CHR_AW-1:0]     chr_mem_addr_o,
  output logic [2:0]            nametable_layout_o,
  output logic                  prg_ram_en_o
);
  logic [4:0] ctrl_q, ctrl_d, chr0_q, chr0_d, chr1_q, chr1_d, prg_q, prg_d, shift_q, shift_d, val, csel;
  logic [2:0] count_q, count_d;
  logic       prev_wr_q, prev_wr_d, acc, a18, a14, unused_bits;
  logic [1:0] sel;
  logic [3:0] bank;
  logic [18:0] prg_full;
  logic [14:0] ram_full;
  logic [16:0] chr_full;
  assign unused_bits = ^{mapper_addr_i[12:0], mapper_wr_data_i[6:1]};
  assign acc = mapper_wr_i & cpu_cycle_i & ~((WR_FILTER != 0) & prev_wr_q);
  assign sel = mapper_addr_i[14:13];
  assign val = {mapper_wr_data_i[0], shift_q[4:1]};
  always_comb begin
    prev_wr_d = cpu_cycle_i ? mapper_wr_i : prev_wr_q;
    shift_d = shift_q;
    count_d = count_q;
    ctrl_d = ctrl_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    prg_d = prg_q;
    if (acc) begin
      if (mapper_wr_data_i[7]) begin
        shift_d = '0;
        count_d = '0;
        ctrl_d = ctrl_q | 5'h0C;
      end else if (count_q != 3'd4) begin
        shift_d = val;
        count_d = count_q + 3'd1;
      end else begin
        shift_d = '0;
        count_d = '0;
        ctrl_d = (sel == 2'd0) ? val : ctrl_q;
        chr0_d = (sel == 2'd1) ? val : chr0_q;
        chr1_d = (sel == 2'd2) ? val : chr1_q;
        prg_d = (sel == 2'd3) ? val : prg_q;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= 5'h0C;
      chr0_q <= '0;
      chr1_q <= '0;
      prg_q <= '0;
      shift_q <= '0;
      count_q <= '0;
      prev_wr_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q <= prg_d;
      shift_q <= shift_d;
      count_q <= count_d;
      prev_wr_q <= prev_wr_d;
    end
  end
  always_comb begin
    csel = (ctrl_q[4] & chr_mem_addr_i[12]) ? chr1_q : chr0_q;
    a14 = prg_rom_addr_i[14];
    a18 = chr_mem_is_ram_i & prg_rom_is_512k_i & csel[4];
    bank = ctrl_q[3] ? (ctrl_q[2] ? (a14 ? 4'hF : prg_q[3:0]) : (a14 ? prg_q[3:0] : 4'h0))
                     : {prg_q[3:1], a14};
    prg_full = {a18, bank, prg_rom_addr_i[13:0]};
    ram_full = {chr_mem_is_ram_i & prg_rom_is_512k_i & csel[3],
                chr_mem_is_ram_i & (prg_rom_is_512k_i ? csel[2] : csel[3]),
                prg_ram_addr_i};
    chr_full = ctrl_q[4] ? {csel, chr_mem_addr_i[11:0]} : {chr0_q[4:1], chr_mem_addr_i};
    prg_rom_addr_o = PRG_ROM_AW'(prg_full) & prg_rom_mask_i;
    prg_ram_addr_o = PRG_RAM_AW'(ram_full);
    chr_mem_addr_o = CHR_AW'(chr_full) & chr_mem_mask_i;
    nametable_layout_o = {1'b0, ctrl_q[1:0]};
    prg_ram_en_o = (MMC1B != 0) ? ~prg_q[4] : 1'b1;
  end
endmodule
